// File: rtl/iconn_bus_arbiter.sv
// iconn_bus_arbiter: round-robin owner selection for one shared interconnect
// net segment. Each gnt bit gates one driver's output enable. An idle
// turnaround follows every release so two drivers never overlap on the net.
//
// Optional build macro IBUS_TIMEOUT_EN: enables a hold counter that forces a
// release after MAX_HOLD consecutive grant cycles, with a one-cycle timeout
// pulse. When undefined, a grant lasts as long as the owner's request.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus undriven; arbitrate among pending requests this cycle
// GRANT | one driver owns the bus; held while req[owner] stays high
// TURN  | bus undriven for TURN_CYCLES cycles; requests stay pending

module iconn_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_HOLD    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     turn,
  output logic                     timeout
);

  localparam int OW = $clog2(N_REQ);

  // Parameter sanity: catch illegal configurations at elaboration.
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("iconn_bus_arbiter: N_REQ out of range 2..16");
  end
  if (TURN_CYCLES < 0 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("iconn_bus_arbiter: TURN_CYCLES out of range 0..15");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("iconn_bus_arbiter: MAX_HOLD out of range 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_REQ-1:0] gnt_d;
  logic [OW-1:0]   owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [3:0]      tcnt_q, tcnt_d;
  logic            pick_valid;
  logic [OW-1:0]   pick_idx;
  logic            release_now;

`ifdef IBUS_TIMEOUT_EN
  logic [7:0]      hold_q, hold_d;
  logic            timeout_d;
`endif

  // Round-robin pick: first set request at or above the pointer, wrapping.
  // Scanning from the far end down lets the nearest candidate win last.
  always_comb begin
    int j;
    j          = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr_q) + i) % N_REQ;
      if (req[j]) begin
        pick_valid = 1'b1;
        pick_idx   = OW'(j);
      end
    end
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt;
    owner_d     = owner;
    ptr_d       = ptr_q;
    tcnt_d      = tcnt_q;
    release_now = 1'b0;
`ifdef IBUS_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          state_d         = GRANT;
`ifdef IBUS_TIMEOUT_EN
          hold_d          = 8'd1;
`endif
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          release_now = 1'b1;
`ifdef IBUS_TIMEOUT_EN
        end else if (hold_q == 8'(MAX_HOLD)) begin
          release_now = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
`endif
        end
        if (release_now) begin
          gnt_d = '0;
          ptr_d = (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);
          if (TURN_CYCLES > 0) begin
            state_d = TURN;
            tcnt_d  = 4'(TURN_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      TURN: begin
        if (tcnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset releases the bus on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
`ifdef IBUS_TIMEOUT_EN
      hold_q  <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      owner   <= owner_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
`ifdef IBUS_TIMEOUT_EN
      hold_q  <= hold_d;
      timeout <= timeout_d;
`endif
    end
  end

`ifndef IBUS_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  assign busy = |gnt;
  assign turn = (state_q == TURN);

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_no_turn : assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> !turn);
  a_busy_match  : assert property (@(posedge clk) disable iff (rst) busy == (|gnt));
`endif

endmodule

// File: tb/tb_iconn_bus_arbiter.sv
// Directed and random checks of iconn_bus_arbiter (N_REQ=4, TURN_CYCLES=2,
// MAX_HOLD=8). Outputs are sampled 1 ns after each rising edge.

module tb_iconn_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       turn;
  logic       timeout;

  int total;
  int bad;

  iconn_bus_arbiter #(
    .N_REQ(4),
    .TURN_CYCLES(2),
    .MAX_HOLD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt),
    .owner(owner),
    .busy(busy),
    .turn(turn),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       turn;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    int zeros;
    int others[4];
    logic [3:0] prev_gnt;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b0000;

    // rst, req -> gnt, owner, busy, turn after the next edge
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};

    for (int v = 0; v < 26; v++) begin
      rst = vecs[v].rst;
      req = vecs[v].req;
      tick();
      check($sformatf("vec%0d gnt", v), int'(gnt), int'(vecs[v].gnt));
      check($sformatf("vec%0d busy", v), int'(busy), int'(vecs[v].busy));
      check($sformatf("vec%0d turn", v), int'(turn), int'(vecs[v].turn));
      check($sformatf("vec%0d timeout", v), int'(timeout), 0);
      if (vecs[v].busy || vecs[v].rst)
        check($sformatf("vec%0d owner", v), int'(owner), int'(vecs[v].owner));
    end

    // All four requesting; each owner holds 3 cycles, drops for one cycle.
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    zeros = 0;
    for (int g = 0; g < 5; g++) begin
      tick();
      while (gnt == 4'b0000 && zeros < 20) begin
        zeros++;
        tick();
      end
      if (gnt == 4'b0000) begin
        check($sformatf("rr grant %0d arrived", g), 0, 1);
        break;
      end
      if (g > 0) check($sformatf("rr gap before grant %0d", g), zeros, 3);
      check($sformatf("rr owner %0d", g), int'(owner), exp_order[g]);
      check($sformatf("rr gnt %0d", g), int'(gnt), 1 << exp_order[g]);
      tick();
      tick();
      check($sformatf("rr hold %0d", g), int'(gnt), 1 << exp_order[g]);
      req[exp_order[g]] = 1'b0;
      tick();
      check($sformatf("rr release %0d", g), int'(gnt), 0);
      check($sformatf("rr turn %0d", g), int'(turn), 1);
      zeros = 1;
      req[exp_order[g]] = 1'b1;
    end

`ifdef IBUS_TIMEOUT_EN
    // Permanent requests from 0 and 1: forced release every 8 grant cycles.
    do_reset();
    req = 4'b0011;
    for (int r = 0; r < 3; r++) begin
      tick();
      if (r > 0) begin
        check($sformatf("to gap turn %0d", r), int'(turn), 1);
        tick();
        check($sformatf("to gap idle %0d", r), int'(gnt), 0);
        tick();
      end
      for (int c = 0; c < 8; c++) begin
        check($sformatf("to hold r%0d c%0d", r, c), int'(gnt), 1 << (r % 2));
        check($sformatf("to quiet r%0d c%0d", r, c), int'(timeout), 0);
        tick();
      end
      check($sformatf("to release %0d", r), int'(gnt), 0);
      check($sformatf("to pulse %0d", r), int'(timeout), 1);
    end
    tick();
    check("to pulse width", int'(timeout), 0);
`else
    // Without the timeout feature a held request keeps the bus indefinitely.
    do_reset();
    req = 4'b0011;
    tick();
    for (int c = 0; c < 40; c++) begin
      check($sformatf("hold c%0d gnt", c), int'(gnt), 1);
      check($sformatf("hold c%0d timeout", c), int'(timeout), 0);
      tick();
    end
`endif

    // Random level requests: invariants, turnaround gap, fairness.
    do_reset();
    prev_gnt = 4'b0000;
    zeros    = 100;
    others   = '{0, 0, 0, 0};
    for (int c = 0; c < 10000; c++) begin
      tick();
      check("rand onehot0", int'($onehot0(gnt)), 1);
      check("rand busy", int'(busy), int'(|gnt));
      if (gnt != 4'b0000) check("rand gnt during turn", int'(turn), 0);
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        check("rand gap", int'(zeros >= 3), 1);
        check("rand owner match", int'(gnt), 1 << owner);
        for (int i = 0; i < 4; i++) begin
          if (i == int'(owner)) begin
            others[i] = 0;
          end else if (req[i]) begin
            others[i]++;
            check($sformatf("rand starve req%0d", i), int'(others[i] <= 3), 1);
          end
        end
      end
      for (int i = 0; i < 4; i++) if (!req[i]) others[i] = 0;
      if (gnt == 4'b0000) zeros++;
      else zeros = 0;
      prev_gnt = gnt;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
